// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the uart_tx arbiter.
// The tag-byte variant is selected with the UART_ARB_TAG_EN macro.
package uart_arb_pkg;

    localparam int BYTE_W = 8;
    localparam logic [4:0] TAG_PREFIX = 5'b10100;

    typedef enum logic [2:0] {
        SYNC       = 3'd0,
        IDLE       = 3'd1,
        LAUNCH_TAG = 3'd2,
        LAUNCH     = 3'd3,
        WAIT_DONE  = 3'd4,
        RECOVER    = 3'd5
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte ports plus the uart_tx launch/status signals.
// master = arbiter side, slave = producers and transmitter side.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    // Requester k holds i_Req_Valid[k] with a stable byte until it sees
    // o_Req_Ready[k] high for one cycle; only then may it drop or change.
    logic [N_REQ-1:0]        i_Req_Valid;
    logic [BYTE_W*N_REQ-1:0] i_Req_Data;
    logic [N_REQ-1:0]        o_Req_Ready;
    logic [N_REQ-1:0]        o_Grant;
    logic                    o_Tx_DV;
    logic [BYTE_W-1:0]       o_Tx_Byte;
    logic                    i_Tx_Active;
    logic                    i_Tx_Done;
    logic                    o_Busy;

    modport master (
        input  i_Req_Valid, i_Req_Data, i_Tx_Active, i_Tx_Done,
        output o_Req_Ready, o_Grant, o_Tx_DV, o_Tx_Byte, o_Busy
    );

    modport slave (
        output i_Req_Valid, i_Req_Data, i_Tx_Active, i_Tx_Done,
        input  o_Req_Ready, o_Grant, o_Tx_DV, o_Tx_Byte, o_Busy
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: the first set bit of i_Valid
// searching upward from i_Last_Id+1 and wrapping modulo N.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    i_Valid,
    input  logic [ID_W-1:0] i_Last_Id,
    output logic            o_Found,
    output logic [ID_W-1:0] o_Id
);

    // Walk offsets from farthest to nearest so the nearest candidate wins.
    always_comb begin
        o_Found = 1'b0;
        o_Id    = '0;
        for (int i = N; i >= 1; i--) begin
            for (int k = 0; k < N; k++) begin
                if (i_Valid[k] && (k == (int'(i_Last_Id) + i) % N)) begin
                    o_Found = 1'b1;
                    o_Id    = ID_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers.
// Define UART_ARB_TAG_EN to precede each granted byte with a tag byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    uart_tx_arbiter_if.master  bus,
    output arb_state_t         o_State
);

    localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              busy_q;
    logic              found;
    logic [ID_W-1:0]   pick_id;
    logic [BYTE_W-1:0] pick_byte;
    logic              tx_dv;
    logic [BYTE_W-1:0] tx_byte;
    logic [N_REQ-1:0]  req_ready;
`ifdef UART_ARB_TAG_EN
    logic              tag_sent_q, tag_sent_d;
`endif

    rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
        .i_Valid   (bus.i_Req_Valid),
        .i_Last_Id (last_id_q),
        .o_Found   (found),
        .o_Id      (pick_id)
    );

    always_comb begin
        pick_byte = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_id == ID_W'(k)) pick_byte = bus.i_Req_Data[k*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= SYNC;
            id_q       <= '0;
            last_id_q  <= LAST_INIT;
            byte_q     <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
`ifdef UART_ARB_TAG_EN
            tag_sent_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            last_id_q  <= last_id_d;
            byte_q     <= byte_d;
            grant_q    <= grant_d;
            busy_q     <= (state_d != IDLE);
`ifdef UART_ARB_TAG_EN
            tag_sent_q <= tag_sent_d;
`endif
        end
    end

    // SYNC waits out any frame left running by a transmitter that ignores reset.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        byte_d    = byte_q;
        grant_d   = grant_q;
        tx_dv     = 1'b0;
        tx_byte   = '0;
        req_ready = '0;
`ifdef UART_ARB_TAG_EN
        tag_sent_d = tag_sent_q;
`endif
        case (state_q)
            SYNC: begin
                if (!bus.i_Tx_Active && !bus.i_Tx_Done) state_d = IDLE;
            end
            IDLE: begin
                if (found) begin
                    id_d    = pick_id;
                    byte_d  = pick_byte;
                    grant_d = ONE_HOT_0 << pick_id;
`ifdef UART_ARB_TAG_EN
                    state_d = LAUNCH_TAG;
`else
                    state_d = LAUNCH;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            LAUNCH_TAG: begin
                tx_dv      = 1'b1;
                tx_byte    = {TAG_PREFIX, 3'(id_q)};
                tag_sent_d = 1'b1;
                state_d    = WAIT_DONE;
            end
`endif
            LAUNCH: begin
                tx_dv     = 1'b1;
                tx_byte   = byte_q;
                req_ready = ONE_HOT_0 << id_q;
                last_id_d = id_q;
`ifdef UART_ARB_TAG_EN
                tag_sent_d = 1'b0;
`endif
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.i_Tx_Done) state_d = RECOVER;
            end
            RECOVER: begin
                if (!bus.i_Tx_Done) begin
`ifdef UART_ARB_TAG_EN
                    if (tag_sent_q) begin
                        state_d = LAUNCH;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
`else
                    grant_d = '0;
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                grant_d = '0;
                state_d = SYNC;
            end
        endcase
    end

    assign bus.o_Tx_DV     = tx_dv;
    assign bus.o_Tx_Byte   = tx_byte;
    assign bus.o_Req_Ready = req_ready;
    assign bus.o_Grant     = grant_q;
    assign bus.o_Busy      = busy_q;
    assign o_State         = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// producer traffic, checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N = 4;
`ifdef UART_ARB_TAG_EN
    localparam int FR = 2;
`else
    localparam int FR = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    arb_state_t dbg_state;

    uart_tx_arbiter_if #(.N_REQ(N)) bus_if ();

    uart_tx_arbiter #(.N_REQ(N), .ID_W(3)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus_if),
        .o_State (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int frame_cnt = 0;

    int         mode [N];
    logic [7:0] cur_byte [N];
    bit         cur_valid [N];

    bit         tx_active, tx_done, line_live;
    int         act_cnt, done_cnt;
    logic [7:0] line_byte;
    logic [7:0] exp_q[$];
    logic [7:0] line_log[$];

    int         last_id_m, win_m, done_fall_cyc;
    bit         tag_phase_m, clr_grant_next;
    logic [N-1:0] exp_grant;

    logic         obs_dv;
    logic [N-1:0] obs_rdy;
    logic [7:0]   obs_byte;
    arb_state_t   obs_state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        logic [N-1:0]   v;
        logic [8*N-1:0] d;
        v = '0;
        d = '0;
        for (int k = 0; k < N; k++) begin
            if (cur_valid[k]) v = v | (N'(1) << k);
            d = d | ((8*N)'(cur_byte[k]) << (8 * k));
        end
        bus_if.i_Req_Valid = v;
        bus_if.i_Req_Data  = d;
        bus_if.i_Tx_Active = tx_active;
        bus_if.i_Tx_Done   = tx_done;
    endtask

    // Transmitter: Active for a random frame length, then Done for 2 cycles.
    task automatic tx_update();
        if (obs_dv) begin
            line_byte = obs_byte;
            line_live = 1'b1;
            tx_active = 1'b1;
            tx_done   = 1'b0;
            act_cnt   = int'($urandom_range(2, 6));
        end else if (tx_active) begin
            act_cnt--;
            if (act_cnt <= 0) begin
                tx_active = 1'b0;
                tx_done   = 1'b1;
                done_cnt  = 2;
                if (line_live) begin
                    frame_cnt++;
                    check("sb_nonempty", 32'(exp_q.size() > 0), 32'(1));
                    if (exp_q.size() > 0) check("line_byte", 32'(line_byte), 32'(exp_q.pop_front()));
                    line_log.push_back(line_byte);
                    line_live = 1'b0;
                end
            end
        end else if (tx_done) begin
            done_cnt--;
            if (done_cnt <= 0) begin
                tx_done       = 1'b0;
                done_fall_cyc = cyc;
                if (!tag_phase_m) clr_grant_next = 1'b1;
            end
        end
    endtask

    task automatic prod_update();
        for (int k = 0; k < N; k++) begin
            if (obs_rdy[k]) begin
                if (mode[k] == 2) begin
                    cur_valid[k] = ($urandom_range(0, 1) == 1);
                    cur_byte[k]  = 8'($urandom_range(0, 255));
                end else if (mode[k] != 1) begin
                    cur_valid[k] = 1'b0;
                end
            end else if (!cur_valid[k] && mode[k] == 2 && $urandom_range(0, 3) == 0) begin
                cur_valid[k] = 1'b1;
                cur_byte[k]  = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // One clock: observe at negedge, check against the model, then drive.
    task automatic step();
        logic [N-1:0] v, g, rdy_exp;
        int win;
        @(negedge clk);
        cyc++;
        v         = bus_if.i_Req_Valid;
        g         = bus_if.o_Grant;
        obs_dv    = bus_if.o_Tx_DV;
        obs_rdy   = bus_if.o_Req_Ready;
        obs_byte  = bus_if.o_Tx_Byte;
        obs_state = dbg_state;
        rdy_exp   = '0;
        if (obs_dv) dv_cnt++;
        if (rst) begin
            check("rst_dv", 32'(obs_dv), 32'(0));
            check("rst_ready", 32'(obs_rdy), 32'(0));
            check("rst_grant", 32'(g), 32'(0));
            check("rst_byte", 32'(obs_byte), 32'(0));
            check("rst_busy", 32'(bus_if.o_Busy), 32'(0));
            last_id_m      = N - 1;
            exp_grant      = '0;
            tag_phase_m    = 1'b0;
            clr_grant_next = 1'b0;
        end else begin
            if (clr_grant_next) begin
                exp_grant      = '0;
                clr_grant_next = 1'b0;
            end
            if (obs_dv) begin
                check("dv_tx_idle", 32'({tx_active, tx_done}), 32'(0));
                check("dv_gap", 32'((cyc - done_fall_cyc) >= (tag_phase_m ? 1 : 2)), 32'(1));
                if (!tag_phase_m) begin
                    win = -1;
                    for (int i = 1; i <= N; i++) begin
                        if (win < 0 && v[(last_id_m + i) % N]) win = (last_id_m + i) % N;
                    end
                    check("dv_had_valid", 32'(win >= 0), 32'(1));
                    if (win < 0) win = 0;
                    win_m     = win;
                    exp_grant = N'(1) << win;
`ifdef UART_ARB_TAG_EN
                    exp_q.push_back({TAG_PREFIX, 3'(win)});
                    tag_phase_m = 1'b1;
`else
                    exp_q.push_back(cur_byte[win]);
                    rdy_exp   = exp_grant;
                    last_id_m = win;
`endif
                end else begin
                    exp_q.push_back(cur_byte[win_m]);
                    rdy_exp     = exp_grant;
                    last_id_m   = win_m;
                    tag_phase_m = 1'b0;
                end
            end
            check("ready", 32'(obs_rdy), 32'(rdy_exp));
            check("grant", 32'(g), 32'(exp_grant));
            if (exp_grant != '0) check("busy", 32'(bus_if.o_Busy), 32'(1));
        end
        tx_update();
        prod_update();
        drive_inputs();
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            step();
            if (obs_state == IDLE) ok = 1'b1;
        end
        check("reach_idle", 32'(ok), 32'(1));
    endtask

    task automatic wait_dv(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            step();
            if (obs_dv) ok = 1'b1;
        end
        check("dv_seen", 32'(ok), 32'(1));
    endtask

    task automatic drain(input int max_cyc);
        bit ok = 1'b0;
        bit any_v;
        for (int k = 0; k < N; k++) mode[k] = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            step();
            any_v = 1'b0;
            for (int k = 0; k < N; k++) if (cur_valid[k]) any_v = 1'b1;
            if (!any_v && !tx_active && !tx_done && obs_state == IDLE) ok = 1'b1;
        end
        check("drain", 32'(ok), 32'(1));
    endtask

    initial begin
        int base;
        logic [7:0] want;
        for (int k = 0; k < N; k++) begin
            mode[k]      = 0;
            cur_valid[k] = 1'b0;
            cur_byte[k]  = '0;
        end
        last_id_m = N - 1; win_m = 0; done_fall_cyc = -100;
        tag_phase_m = 1'b0; clr_grant_next = 1'b0; exp_grant = '0;
        line_live = 1'b0; tx_done = 1'b0; done_cnt = 0;
        tx_active = 1'b1; act_cnt = 6;
        rst = 1'b1;
        drive_inputs();

        // Reset while the transmitter is mid-frame.
        step(); step();
        rst = 1'b0;
        step();
        check("sync_while_active", 32'(obs_state), 32'(SYNC));
        wait_idle(40);
        check("sync_exit_quiet", 32'({tx_active, tx_done}), 32'(0));

        // Single requester 2 with 0x5A: DV one cycle after valid.
        cur_valid[2] = 1'b1; cur_byte[2] = 8'h5A;
        drive_inputs();
        step();
        check("lat_dv", 32'(obs_dv), 32'(1));
`ifdef UART_ARB_TAG_EN
        check("lat_byte", 32'(obs_byte), 32'(8'hA2));
        check("lat_ready", 32'(obs_rdy), 32'(0));
`else
        check("lat_byte", 32'(obs_byte), 32'(8'h5A));
        check("lat_ready", 32'(obs_rdy), 32'(4'b0100));
`endif
        drain(100);

        // All four continuously valid after a fresh reset.
        rst = 1'b1; step(); rst = 1'b0;
        wait_idle(10);
        line_log.delete();
        for (int k = 0; k < N; k++) begin
            mode[k] = 1; cur_valid[k] = 1'b1; cur_byte[k] = 8'h10 + 8'(k);
        end
        drive_inputs();
        for (int i = 0; i < 400 && line_log.size() < 5 * FR; i++) step();
        check("rr_frames", 32'(line_log.size() >= 5 * FR), 32'(1));
        if (line_log.size() >= 5 * FR) begin
            for (int i = 0; i < 5; i++) begin
                want = 8'h10 + 8'(i % N);
`ifdef UART_ARB_TAG_EN
                check("rr_tag", 32'(line_log[2*i]), 32'({TAG_PREFIX, 3'(i % N)}));
`endif
                check("rr_order", 32'(line_log[FR*i+FR-1]), 32'(want));
            end
        end
        drain(300);

        // Requester 1 arrives while requester 3 is being sent.
        base = line_log.size();
        cur_valid[3] = 1'b1; cur_byte[3] = 8'h33;
        drive_inputs();
        wait_dv(10);
        cur_valid[1] = 1'b1; cur_byte[1] = 8'h11;
        drive_inputs();
        drain(200);
        check("late_frames", 32'(line_log.size() - base), 32'(2 * FR));
        if (line_log.size() >= base + 2 * FR) begin
            check("late_first", 32'(line_log[base+FR-1]), 32'(8'h33));
            check("late_second", 32'(line_log[base+2*FR-1]), 32'(8'h11));
        end

        // Reset while waiting for Done; next launch must wait for quiescence.
        cur_valid[0] = 1'b1; cur_byte[0] = 8'h99;
        drive_inputs();
        wait_dv(10);
        step();
        check("in_wait_done", 32'(obs_state), 32'(WAIT_DONE));
        cur_valid[1] = 1'b1; cur_byte[1] = 8'h22;
        rst = 1'b1;
        drive_inputs();
        step();
        check("rst_to_sync", 32'(obs_state), 32'(SYNC));
        rst = 1'b0;
        drain(200);

`ifdef UART_ARB_TAG_EN
        // Tag byte precedes data; one ready pulse, at the data launch.
        base = line_log.size();
        cur_valid[3] = 1'b1; cur_byte[3] = 8'h41;
        drive_inputs();
        drain(100);
        check("tag_frames", 32'(line_log.size() - base), 32'(2));
        if (line_log.size() >= base + 2) begin
            check("tag_byte", 32'(line_log[base]), 32'(8'hA3));
            check("tag_data", 32'(line_log[base+1]), 32'(8'h41));
        end
`endif

        // Random traffic with occasional resets.
        for (int k = 0; k < N; k++) mode[k] = 2;
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        drain(400);
        check("sb_empty", 32'(exp_q.size()), 32'(0));
        check("dv_per_frame", 32'(dv_cnt), 32'(frame_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one uart_tx byte transmitter between N_REQ byte producers, e.g. status reporter, debug dumper and echo path.
- Each requester has a valid/ready byte port.
- The block issues one-cycle o_Tx_DV launches and tracks i_Tx_Active/i_Tx_Done so a launch never lands while the transmitter is busy or in its cleanup cycle.
- Sits between the producers and the uart_tx instance; the transmitter itself is not modified.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 3, width of requester index; must satisfy 2**ID_W >= N_REQ.

Ports:
- i_Clock  in  1  system clock, all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req_Valid  in  N_REQ  per-requester byte valid; held until matching ready.
- i_Req_Data  in  8*N_REQ  requester k byte at [8k+7:8k]; stable while valid.
- o_Req_Ready  out  N_REQ  one-cycle pulse, byte of that requester accepted.
- o_Grant  out  N_REQ  one-hot current owner, zero when idle.
- o_Tx_DV  out  1  one-cycle launch strobe to transmitter.
- o_Tx_Byte  out  8  byte to transmitter, valid with o_Tx_DV.
- i_Tx_Active  in  1  transmitter active flag.
- i_Tx_Done  in  1  transmitter done flag (high for 2 cycles at end of frame).
- o_Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; state SYNC; round-robin pointer last_id = N_REQ-1, so requester 0 has first priority.
- The transmitter has no reset, so reset mid-frame never corrupts a launch: SYNC leaves to IDLE only when i_Tx_Active==0 && i_Tx_Done==0.
- IDLE:
  - If any valid, select the first valid index searching from last_id+1 and wrapping modulo N_REQ.
  - Register the winner's id and byte, set o_Grant, go to LAUNCH.
  - With no valid, stay in IDLE.
- LAUNCH (1 cycle):
  - o_Tx_DV=1, o_Tx_Byte=latched byte, o_Req_Ready[id]=1.
  - last_id <= id; go to WAIT_DONE.
  - Latency from valid seen in IDLE to DV is 1 cycle.
- WAIT_DONE: hold o_Grant; wait for i_Tx_Done==1, then go to RECOVER.
- RECOVER:
  - Wait for i_Tx_Done==0, i.e. the transmitter is back in its idle state.
  - Then clear o_Grant and go to IDLE.
  - Next launch is at the earliest 2 cycles after Done falls.
- Arbitration:
  - Strictly one byte per grant, so a continuously valid requester cannot starve others.
  - With all N_REQ valid, grants rotate 0,1,..,N_REQ-1,0.
- Valid dropped by a requester before ready: the arbiter already latched the byte in IDLE and sends it anyway. A requester may only deassert after ready.
- Simultaneous new valids during WAIT_DONE/RECOVER are ignored until IDLE.
- o_Tx_DV is never asserted outside LAUNCH.
- o_Req_Ready is at most one-hot and only in LAUNCH.
- Unused state encodings go to SYNC.

Optional Feature:
- Macro UART_ARB_TAG_EN.
- When defined, each granted byte is preceded by a tag byte {5'b10100, id[2:0]}:
  - Sequence is LAUNCH_TAG → WAIT_DONE → RECOVER → LAUNCH (data) → WAIT_DONE → RECOVER → IDLE.
  - Grant is held across both frames.
  - o_Req_Ready pulses only at the data launch.
- When undefined, no tag logic or states exist and behaviour is exactly as above.

Decomposition:
- Package uart_arb_pkg:
  - state enum (SYNC, IDLE, LAUNCH_TAG, LAUNCH, WAIT_DONE, RECOVER);
  - TAG_PREFIX = 5'b10100;
  - byte width constant 8.
- One sub-module, rr_pick:
  - combinational round-robin first-one finder;
  - inputs: valid vector and last_id; outputs: found flag and winning id.
  - Reusable for other shared resources.

Test Plan:
- Reset with transmitter model mid-frame (Active=1) → arbiter stays in SYNC, o_Tx_DV=0 until Active=0 and Done=0, then enters IDLE.
- Only requester 2 valid with 0x5A → o_Tx_DV one cycle later with o_Tx_Byte=0x5A, o_Req_Ready=4'b0100 same cycle, o_Grant=4'b0100 until Done falls.
- All 4 valid continuously with bytes 0x10..0x13 → transmitted order 0x10,0x11,0x12,0x13,0x10; no DV while Active or Done is high.
- Requester 1 valid, arbiter sending for requester 3 → requester 1 granted only after RECOVER exits; exactly one DV per frame.
- With UART_ARB_TAG_EN, requester 3 sends 0x41 → bytes 0xA3 then 0x41 on line, single ready pulse at second launch.
- Reset asserted in WAIT_DONE → all outputs 0 next cycle; next launch waits for transmitter quiescence.
